// File: rtl/tod_counter_if.sv
// Signal bundle for the time-of-day counter: tick/load control, preset values, counts and pulses.
// Alarm signals exist only when TOD_COUNTER_ALARM_EN is defined.
interface tod_counter_if #(
    parameter int SW = 6,
    parameter int MW = 6,
    parameter int HW = 5
) ();
    logic          tick;
    logic          dir;
    logic          load;
    logic [SW-1:0] load_sec;
    logic [MW-1:0] load_min;
    logic [HW-1:0] load_hr;
    logic [SW-1:0] count_sec;
    logic [MW-1:0] count_min;
    logic [HW-1:0] count_hr;
    logic          wrap_sec;
    logic          wrap_min;
    logic          wrap_hr;
    logic          load_err;
`ifdef TOD_COUNTER_ALARM_EN
    logic          alarm_wr;
    logic [SW-1:0] alarm_sec;
    logic [MW-1:0] alarm_min;
    logic [HW-1:0] alarm_hr;
    logic          alarm_hit;

    modport slave (
        input  tick, dir, load, load_sec, load_min, load_hr,
        input  alarm_wr, alarm_sec, alarm_min, alarm_hr,
        output count_sec, count_min, count_hr, wrap_sec, wrap_min, wrap_hr, load_err,
        output alarm_hit
    );
    modport master (
        output tick, dir, load, load_sec, load_min, load_hr,
        output alarm_wr, alarm_sec, alarm_min, alarm_hr,
        input  count_sec, count_min, count_hr, wrap_sec, wrap_min, wrap_hr, load_err,
        input  alarm_hit
    );
`else
    modport slave (
        input  tick, dir, load, load_sec, load_min, load_hr,
        output count_sec, count_min, count_hr, wrap_sec, wrap_min, wrap_hr, load_err
    );
    modport master (
        output tick, dir, load, load_sec, load_min, load_hr,
        input  count_sec, count_min, count_hr, wrap_sec, wrap_min, wrap_hr, load_err
    );
`endif
endinterface

// File: rtl/tod_counter.sv
// Up/down seconds:minutes:hours counter with presettable load and registered wrap pulses.
// Optional alarm comparator enabled by defining TOD_COUNTER_ALARM_EN.
module tod_counter #(
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60,
    parameter int HR_MOD  = 24
) (
    input logic          clk,
    input logic          rst,
    tod_counter_if.slave bus
);
    localparam int SW = ($clog2(SEC_MOD) > 1) ? $clog2(SEC_MOD) : 1;
    localparam int MW = ($clog2(MIN_MOD) > 1) ? $clog2(MIN_MOD) : 1;
    localparam int HW = ($clog2(HR_MOD)  > 1) ? $clog2(HR_MOD)  : 1;

    localparam logic [SW-1:0] SEC_MAX = SW'(SEC_MOD - 1);
    localparam logic [MW-1:0] MIN_MAX = MW'(MIN_MOD - 1);
    localparam logic [HW-1:0] HR_MAX  = HW'(HR_MOD - 1);

    logic [SW-1:0] sec_q, sec_nxt;
    logic [MW-1:0] min_q, min_nxt;
    logic [HW-1:0] hr_q,  hr_nxt;
    logic          sec_end, min_end, hr_end;
    logic          sec_ok, min_ok, hr_ok;
    logic          wrap_sec_q, wrap_min_q, wrap_hr_q, load_err_q;

    // A field is at its end when the next step in the current direction wraps it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sec_nxt = sec_q;
        min_nxt = min_q;
        hr_nxt  = hr_q;
        sec_end = bus.dir ? (sec_q == '0) : (sec_q == SEC_MAX);
        min_end = bus.dir ? (min_q == '0) : (min_q == MIN_MAX);
        hr_end  = bus.dir ? (hr_q  == '0) : (hr_q  == HR_MAX);

        if (sec_end)      sec_nxt = bus.dir ? SEC_MAX : '0;
        else if (bus.dir) sec_nxt = sec_q - SW'(1);
        else              sec_nxt = sec_q + SW'(1);

        if (sec_end) begin
            if (min_end)      min_nxt = bus.dir ? MIN_MAX : '0;
            else if (bus.dir) min_nxt = min_q - MW'(1);
            else              min_nxt = min_q + MW'(1);
        end

        if (sec_end && min_end) begin
            if (hr_end)       hr_nxt = bus.dir ? HR_MAX : '0;
            else if (bus.dir) hr_nxt = hr_q - HW'(1);
            else              hr_nxt = hr_q + HW'(1);
        end

        sec_ok = 32'(bus.load_sec) < SEC_MOD;
        min_ok = 32'(bus.load_min) < MIN_MOD;
        hr_ok  = 32'(bus.load_hr)  < HR_MOD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            wrap_sec_q <= 1'b0;
            wrap_min_q <= 1'b0;
            wrap_hr_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_sec_q <= 1'b0;
            wrap_min_q <= 1'b0;
            wrap_hr_q  <= 1'b0;
            load_err_q <= 1'b0;
            // Load wins over a same-cycle tick; the tick is dropped entirely.
            if (bus.load) begin
                if (sec_ok) sec_q <= bus.load_sec;
                if (min_ok) min_q <= bus.load_min;
                if (hr_ok)  hr_q  <= bus.load_hr;
                load_err_q <= !(sec_ok && min_ok && hr_ok);
            end else if (bus.tick) begin
                sec_q      <= sec_nxt;
                min_q      <= min_nxt;
                hr_q       <= hr_nxt;
                wrap_sec_q <= sec_end;
                wrap_min_q <= sec_end && min_end;
                wrap_hr_q  <= sec_end && min_end && hr_end;
            end
        end
    end

    assign bus.count_sec = sec_q;
    assign bus.count_min = min_q;
    assign bus.count_hr  = hr_q;
    assign bus.wrap_sec  = wrap_sec_q;
    assign bus.wrap_min  = wrap_min_q;
    assign bus.wrap_hr   = wrap_hr_q;
    assign bus.load_err  = load_err_q;

`ifdef TOD_COUNTER_ALARM_EN
    logic [SW-1:0] alarm_sec_q;
    logic [MW-1:0] alarm_min_q;
    logic [HW-1:0] alarm_hr_q;
    logic          armed_q, alarm_hit_q, alarm_match;

    // Compare against the post-tick value so the hit lines up with the displayed count.
    assign alarm_match = (sec_nxt == alarm_sec_q) && (min_nxt == alarm_min_q) &&
                         (hr_nxt == alarm_hr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_sec_q <= '0;
            alarm_min_q <= '0;
            alarm_hr_q  <= '0;
            armed_q     <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_hit_q <= !bus.load && bus.tick && armed_q && alarm_match;
            if (bus.alarm_wr) begin
                alarm_sec_q <= bus.alarm_sec;
                alarm_min_q <= bus.alarm_min;
                alarm_hr_q  <= bus.alarm_hr;
                armed_q     <= 1'b1;
            end
        end
    end

    assign bus.alarm_hit = alarm_hit_q;
`endif
endmodule

// File: tb/tb_tod_counter.sv
// Directed self-checking bench for tod_counter (default 60/60/24 chain; alarm case when
// TOD_COUNTER_ALARM_EN is defined, using a second instance with SEC_MOD=10).
module tb_tod_counter;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    tod_counter_if #(.SW(6), .MW(6), .HW(5)) bus ();

    tod_counter #(.SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef TOD_COUNTER_ALARM_EN
    tod_counter_if #(.SW(4), .MW(6), .HW(5)) abus ();

    tod_counter #(.SEC_MOD(10), .MIN_MOD(60), .HR_MOD(24)) dut_alarm (
        .clk (clk),
        .rst (rst),
        .bus (abus.slave)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        bus.load     = 1'b1;
        bus.load_hr  = 5'(h);
        bus.load_min = 6'(m);
        bus.load_sec = 6'(s);
        step();
        bus.load     = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.tick = 1'b1;
        step();
        step();
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec} !== 17'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d:%0d:%0d expected 0:0:0",
                     bus.count_hr, bus.count_min, bus.count_sec);
        end
        tests++;
        if ({bus.wrap_hr, bus.wrap_min, bus.wrap_sec, bus.load_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec, bus.load_err});
        end
        bus.tick = 1'b0;
        rst      = 1'b0;
        step();
    endtask

    task automatic test_full_day();
        int n_ws = 0;
        int n_wm = 0;
        int n_wh = 0;
        bus.dir  = 1'b0;
        bus.tick = 1'b1;
        for (int i = 0; i < 86400; i++) begin
            step();
            n_ws += int'(bus.wrap_sec);
            n_wm += int'(bus.wrap_min);
            n_wh += int'(bus.wrap_hr);
        end
        bus.tick = 1'b0;
        tests++;
        if (n_ws != 1440) begin
            fails++;
            $display("FAIL day_wrap_sec: got %0d expected 1440", n_ws);
        end
        tests++;
        if (n_wm != 24) begin
            fails++;
            $display("FAIL day_wrap_min: got %0d expected 24", n_wm);
        end
        tests++;
        if (n_wh != 1) begin
            fails++;
            $display("FAIL day_wrap_hr: got %0d expected 1", n_wh);
        end
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec} !== 17'd0) begin
            fails++;
            $display("FAIL day_end: got %0d:%0d:%0d expected 0:0:0",
                     bus.count_hr, bus.count_min, bus.count_sec);
        end
    endtask

    task automatic test_wrap_up();
        do_load(23, 59, 59);
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.wrap_hr, bus.wrap_min, bus.wrap_sec}
            !== {5'd23, 6'd59, 6'd59, 3'b000}) begin
            fails++;
            $display("FAIL up_load: got %0d:%0d:%0d wraps %b expected 23:59:59 wraps 000",
                     bus.count_hr, bus.count_min, bus.count_sec,
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
        bus.dir  = 1'b0;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.wrap_hr, bus.wrap_min, bus.wrap_sec}
            !== {17'd0, 3'b111}) begin
            fails++;
            $display("FAIL up_wrap: got %0d:%0d:%0d wraps %b expected 0:0:0 wraps 111",
                     bus.count_hr, bus.count_min, bus.count_sec,
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
        step();
        tests++;
        if ({bus.wrap_hr, bus.wrap_min, bus.wrap_sec} !== 3'b000) begin
            fails++;
            $display("FAIL up_wrap_pulse: got %b expected 000",
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
    endtask

    task automatic test_wrap_down();
        do_load(0, 0, 0);
        bus.dir  = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.wrap_hr, bus.wrap_min, bus.wrap_sec}
            !== {5'd23, 6'd59, 6'd59, 3'b111}) begin
            fails++;
            $display("FAIL down_wrap: got %0d:%0d:%0d wraps %b expected 23:59:59 wraps 111",
                     bus.count_hr, bus.count_min, bus.count_sec,
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
        do_load(7, 5, 0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.wrap_hr, bus.wrap_min, bus.wrap_sec}
            !== {5'd7, 6'd4, 6'd59, 3'b001}) begin
            fails++;
            $display("FAIL down_borrow: got %0d:%0d:%0d wraps %b expected 7:4:59 wraps 001",
                     bus.count_hr, bus.count_min, bus.count_sec,
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
        bus.dir = 1'b0;
    endtask

    task automatic test_load_err();
        do_load(1, 2, 3);
        do_load(1, 60, 5);
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.load_err}
            !== {5'd1, 6'd2, 6'd5, 1'b1}) begin
            fails++;
            $display("FAIL load_err: got %0d:%0d:%0d err %b expected 1:2:5 err 1",
                     bus.count_hr, bus.count_min, bus.count_sec, bus.load_err);
        end
        step();
        tests++;
        if (bus.load_err !== 1'b0) begin
            fails++;
            $display("FAIL load_err_pulse: got %b expected 0", bus.load_err);
        end
        do_load(24, 0, 0);
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.load_err}
            !== {5'd1, 6'd0, 6'd0, 1'b1}) begin
            fails++;
            $display("FAIL load_err_hr: got %0d:%0d:%0d err %b expected 1:0:0 err 1",
                     bus.count_hr, bus.count_min, bus.count_sec, bus.load_err);
        end
    endtask

    task automatic test_load_tick();
        bus.tick = 1'b1;
        do_load(10, 20, 30);
        bus.tick = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.wrap_hr, bus.wrap_min, bus.wrap_sec}
            !== {5'd10, 6'd20, 6'd30, 3'b000}) begin
            fails++;
            $display("FAIL load_tick: got %0d:%0d:%0d wraps %b expected 10:20:30 wraps 000",
                     bus.count_hr, bus.count_min, bus.count_sec,
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
        rst = 1'b1;
        do_load(5, 6, 7);
        rst = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec} !== 17'd0) begin
            fails++;
            $display("FAIL rst_load: got %0d:%0d:%0d expected 0:0:0",
                     bus.count_hr, bus.count_min, bus.count_sec);
        end
    endtask

    task automatic test_hold();
        do_load(12, 34, 56);
        for (int i = 0; i < 4; i++) begin
            bus.dir = ~bus.dir;
            step();
        end
        bus.dir = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec, bus.wrap_hr, bus.wrap_min, bus.wrap_sec}
            !== {5'd12, 6'd34, 6'd56, 3'b000}) begin
            fails++;
            $display("FAIL hold: got %0d:%0d:%0d wraps %b expected 12:34:56 wraps 000",
                     bus.count_hr, bus.count_min, bus.count_sec,
                     {bus.wrap_hr, bus.wrap_min, bus.wrap_sec});
        end
    endtask

    task automatic test_restart();
        do_load(3, 3, 3);
        bus.tick = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.tick = 1'b0;
        tests++;
        if ({bus.count_hr, bus.count_min, bus.count_sec} !== {5'd0, 6'd0, 6'd1}) begin
            fails++;
            $display("FAIL restart: got %0d:%0d:%0d expected 0:0:1",
                     bus.count_hr, bus.count_min, bus.count_sec);
        end
    endtask

`ifdef TOD_COUNTER_ALARM_EN
    task automatic test_alarm();
        int hits = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        abus.alarm_wr  = 1'b1;
        abus.alarm_hr  = 5'd0;
        abus.alarm_min = 6'd0;
        abus.alarm_sec = 4'd3;
        step();
        abus.alarm_wr = 1'b0;
        abus.dir      = 1'b0;
        abus.tick     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            hits += int'(abus.alarm_hit);
        end
        tests++;
        if (abus.alarm_hit !== 1'b1) begin
            fails++;
            $display("FAIL alarm_hit_at_3: got %b expected 1", abus.alarm_hit);
        end
        step();
        abus.tick = 1'b0;
        hits += int'(abus.alarm_hit);
        tests++;
        if (hits != 1) begin
            fails++;
            $display("FAIL alarm_hit_count: got %0d expected 1", hits);
        end
        abus.load     = 1'b1;
        abus.load_hr  = 5'd0;
        abus.load_min = 6'd0;
        abus.load_sec = 4'd3;
        step();
        abus.load = 1'b0;
        tests++;
        if ({abus.count_sec, abus.alarm_hit} !== {4'd3, 1'b0}) begin
            fails++;
            $display("FAIL alarm_load: got sec %0d hit %b expected sec 3 hit 0",
                     abus.count_sec, abus.alarm_hit);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_sec = '0;
        bus.load_min = '0;
        bus.load_hr  = '0;
`ifdef TOD_COUNTER_ALARM_EN
        bus.alarm_wr   = 1'b0;
        bus.alarm_sec  = '0;
        bus.alarm_min  = '0;
        bus.alarm_hr   = '0;
        abus.tick      = 1'b0;
        abus.dir       = 1'b0;
        abus.load      = 1'b0;
        abus.load_sec  = '0;
        abus.load_min  = '0;
        abus.load_hr   = '0;
        abus.alarm_wr  = 1'b0;
        abus.alarm_sec = '0;
        abus.alarm_min = '0;
        abus.alarm_hr  = '0;
`endif
        #1;
        test_reset();
        test_full_day();
        test_wrap_up();
        test_wrap_down();
        test_load_err();
        test_load_tick();
        test_hold();
        test_restart();
`ifdef TOD_COUNTER_ALARM_EN
        test_alarm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
